// File: rtl/nanorv32_irq_arb_pkg.sv
// rtl/nanorv32_irq_arb_pkg.sv - register map, FSM encoding and field widths for the IRQ arbiter.
package nanorv32_irq_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int ID_W   = 3;
  localparam int OFF_W  = 5;

  localparam logic [OFF_W-1:0] OFF_ENABLE  = 5'h00;
  localparam logic [OFF_W-1:0] OFF_PRIO    = 5'h04;
  localparam logic [OFF_W-1:0] OFF_PENDING = 5'h08;
  localparam logic [OFF_W-1:0] OFF_STATUS  = 5'h0C;
  localparam logic [OFF_W-1:0] OFF_EOI     = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } arb_state_e;

  function automatic logic [DATA_W-1:0] status_word(arb_state_e st, logic [ID_W-1:0] id);
    return {22'b0, st, 5'b0, id};
  endfunction

endpackage

// File: rtl/nanorv32_irq_prio_sel.sv
// rtl/nanorv32_irq_prio_sel.sv - combinational winner pick: highest priority, lowest index on ties.
module nanorv32_irq_prio_sel
  import nanorv32_irq_arb_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int PRIO_W  = 2
) (
  input  logic [NUM_IRQ-1:0]        cand,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio,
  output logic                      valid,
  output logic [ID_W-1:0]           id
);

  logic [PRIO_W-1:0] best;

  // Ascending scan with a strict '>' keeps the lowest index among equal priorities.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    best  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand[i] && (!valid || prio[i*PRIO_W +: PRIO_W] > best)) begin
        valid = 1'b1;
        id    = ID_W'(i);
        best  = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/nanorv32_irq_arb.sv
// rtl/nanorv32_irq_arb.sv - APB-programmed interrupt arbiter with edge-latched pending and an IDLE/REQ/ACTIVE handshake.
module nanorv32_irq_arb
  import nanorv32_irq_arb_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int PRIO_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              apb_psel,
  input  logic [ADDR_W-1:0] apb_paddr,
  input  logic              apb_penable,
  input  logic              apb_pwrite,
  input  logic [DATA_W-1:0] apb_pwdata,
  output logic [DATA_W-1:0] apb_prdata,
  output logic              apb_pready,
  output logic              apb_pslverr,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic              cpu_irq,
  output logic [ID_W-1:0]   cpu_irq_id,
  input  logic              cpu_irq_ack
);

  localparam int PRIO_BITS = NUM_IRQ * PRIO_W;

  logic [NUM_IRQ-1:0]   enable, pending, src_q, edge_det, w1c, ack_clr, cand, req_mask;
  logic [PRIO_BITS-1:0] prio;
  logic [ID_W-1:0]      req_id, active_id, sel_id;
  logic                 sel_valid, rst_q, wr, ack_take;
  logic [OFF_W-1:0]     off;
  arb_state_e           state;
  logic                 unused_bits;

  assign apb_pready  = 1'b1;
  assign apb_pslverr = 1'b0;
  assign unused_bits = ^{apb_paddr[ADDR_W-1:OFF_W], apb_pwdata};

  assign off      = apb_paddr[OFF_W-1:0];
  assign wr       = apb_psel && !apb_penable && apb_pwrite;
  // rst_q masks the first post-reset cycle so a source held high through reset is not an edge.
  assign edge_det = irq_src & ~src_q & {NUM_IRQ{~rst_q}};
  assign req_mask = NUM_IRQ'(1) << req_id;
  assign ack_take = (state == ST_REQ) && cpu_irq_ack;
  assign ack_clr  = ack_take ? req_mask : '0;
  assign w1c      = (wr && off == OFF_PENDING) ? apb_pwdata[NUM_IRQ-1:0] : '0;
  assign cand     = pending & enable;
  assign cpu_irq_id = req_id;

  nanorv32_irq_prio_sel #(
    .NUM_IRQ(NUM_IRQ),
    .PRIO_W (PRIO_W)
  ) u_prio_sel (
    .cand (cand),
    .prio (prio),
    .valid(sel_valid),
    .id   (sel_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= '0;
      prio      <= '0;
      pending   <= '0;
      src_q     <= '0;
      rst_q     <= 1'b1;
      active_id <= '0;
      req_id    <= '0;
      cpu_irq   <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      rst_q   <= 1'b0;
      src_q   <= irq_src;
      pending <= (pending & ~(w1c | ack_clr)) | edge_det;
      if (wr && off == OFF_ENABLE) enable <= apb_pwdata[NUM_IRQ-1:0];
      if (wr && off == OFF_PRIO)   prio   <= apb_pwdata[PRIO_BITS-1:0];
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            req_id  <= sel_id;
            cpu_irq <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack beats a same-cycle software clear of the requested bit.
          if (cpu_irq_ack) begin
            active_id <= req_id;
            cpu_irq   <= 1'b0;
            state     <= ST_ACTIVE;
          end else if (|(w1c & req_mask)) begin
            cpu_irq <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (wr && off == OFF_EOI) state <= ST_IDLE;
        end
        default: begin
          cpu_irq <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    apb_prdata = '0;
    if (apb_psel && !apb_pwrite) begin
      case (off)
        OFF_ENABLE:  apb_prdata = DATA_W'(enable);
        OFF_PRIO:    apb_prdata = DATA_W'(prio);
        OFF_PENDING: apb_prdata = DATA_W'(pending);
        OFF_STATUS:  apb_prdata = status_word(state, active_id);
        default:     apb_prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nanorv32_irq_arb.sv
// tb/tb_nanorv32_irq_arb.sv - register table, directed handshake sequences and randomized model comparison.
module tb_nanorv32_irq_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  irq_src;
  logic        cpu_irq, ack;
  logic [2:0]  cpu_irq_id;

  int checks = 0;
  int errors = 0;

  nanorv32_irq_arb #(.NUM_IRQ(8), .PRIO_W(2)) dut (
    .clk(clk), .rst(rst),
    .apb_psel(psel), .apb_paddr(paddr), .apb_penable(penable), .apb_pwrite(pwrite),
    .apb_pwdata(pwdata), .apb_prdata(prdata), .apb_pready(pready), .apb_pslverr(pslverr),
    .irq_src(irq_src), .cpu_irq(cpu_irq), .cpu_irq_id(cpu_irq_id), .cpu_irq_ack(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_idle();
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    psel = 1; pwrite = 1; penable = 0; paddr = a; pwdata = d;
    tick();
    penable = 1;
    tick();
    apb_idle();
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    psel = 1; pwrite = 0; penable = 0; paddr = a;
    #1;
    d = prdata;
    apb_idle();
  endtask

  task automatic check_reg(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(name, d, exp);
  endtask

  task automatic pulse(input logic [7:0] s);
    irq_src = s;
    tick();
    irq_src = '0;
  endtask

  task automatic ack_cycle();
    ack = 1;
    tick();
    ack = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Reference model: per-source arrays, priority resolved by scanning priority levels downward.
  bit m_en[8];
  int m_prio[8];
  bit m_pend[8];
  bit m_prev[8];
  bit m_first;
  int m_state;  // 0 idle, 1 requesting, 2 in service
  int m_id;
  int m_act;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 0; m_prio[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
    end
    m_first = 1; m_state = 0; m_id = 0; m_act = 0;
  endfunction

  function automatic int m_winner();
    for (int p = 3; p >= 0; p--)
      for (int i = 0; i < 8; i++)
        if (m_en[i] && m_pend[i] && m_prio[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    logic [31:0] v;
    v = 0;
    case (int'(a[4:0]))
      0:  for (int i = 0; i < 8; i++) v[i] = m_en[i];
      4:  for (int i = 0; i < 8; i++) v = v | (32'(m_prio[i]) << (2 * i));
      8:  for (int i = 0; i < 8; i++) v[i] = m_pend[i];
      12: v = 32'((m_state << 8) | m_act);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic void m_step(logic s, logic en_, logic wr_, logic [11:0] a,
                                 logic [31:0] d, logic [7:0] src, logic ak);
    bit w;
    int off, win;
    w   = s && !en_ && wr_;
    off = int'(a[4:0]);
    win = m_winner();
    for (int i = 0; i < 8; i++) begin
      if (src[i] && !m_prev[i] && !m_first) m_pend[i] = 1;
      else if (w && off == 8 && d[i]) m_pend[i] = 0;
      else if (m_state == 1 && ak && m_id == i) m_pend[i] = 0;
    end
    case (m_state)
      0: if (win >= 0) begin m_id = win; m_state = 1; end
      1: if (ak) begin m_act = m_id; m_state = 2; end
         else if (w && off == 8 && d[m_id]) m_state = 0;
      default: if (w && off == 16) m_state = 0;
    endcase
    if (w && off == 0) for (int i = 0; i < 8; i++) m_en[i] = d[i];
    if (w && off == 4) for (int i = 0; i < 8; i++) m_prio[i] = int'((d >> (2 * i)) & 3);
    for (int i = 0; i < 8; i++) m_prev[i] = src[i];
    m_first = 0;
  endfunction

  typedef struct {
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[10];
  int   offs[8] = '{0, 4, 8, 8, 12, 16, 16, 20};

  initial begin
    logic [31:0] d;
    bit in_access;
    bit rd;
    int r;

    rst = 1; ack = 0; irq_src = '0;
    apb_idle();
    vt[0] = '{12'h000, 32'hFFFF_FFA5, 12'h000, 32'h0000_00A5};
    vt[1] = '{12'h004, 32'h1234_ABCD, 12'h004, 32'h0000_ABCD};
    vt[2] = '{12'h104, 32'h0000_5555, 12'h004, 32'h0000_5555};
    vt[3] = '{12'h014, 32'hFFFF_FFFF, 12'h014, 32'h0000_0000};
    vt[4] = '{12'h014, 32'hFFFF_FFFF, 12'h000, 32'h0000_00A5};
    vt[5] = '{12'h00C, 32'hFFFF_FFFF, 12'h00C, 32'h0000_0000};
    vt[6] = '{12'h008, 32'h0000_00FF, 12'h008, 32'h0000_0000};
    vt[7] = '{12'h010, 32'h0000_0000, 12'h00C, 32'h0000_0000};
    vt[8] = '{12'h000, 32'h0000_0000, 12'hE00, 32'h0000_0000};
    vt[9] = '{12'h01C, 32'h0000_0001, 12'h010, 32'h0000_0000};

    tick();
    tick();
    check("reset_cpu_irq", cpu_irq, 0);
    check("reset_cpu_irq_id", cpu_irq_id, 0);
    rst = 0;
    tick();
    check_reg("reset_enable", 12'h000, 0);
    check_reg("reset_prio", 12'h004, 0);
    check_reg("reset_pending", 12'h008, 0);
    check_reg("reset_status", 12'h00C, 0);
    check("pready", pready, 1);
    check("pslverr", pslverr, 0);

    for (int i = 0; i < 10; i++) begin
      apb_write(vt[i].waddr, vt[i].wdata);
      check_reg($sformatf("table_%0d", i), vt[i].raddr, vt[i].exp);
    end
    psel = 1; pwrite = 1; paddr = 12'h000; #1;
    check("prdata_on_write", prdata, 0);
    apb_idle();

    // Basic flow: edge at "cycle 10", request at 12, ack at 14, EOI
    apb_write(12'h000, 32'h01);
    pulse(8'h01);
    check("basic_c11_irq", cpu_irq, 0);
    check_reg("basic_c11_pending", 12'h008, 32'h01);
    tick();
    check("basic_c12_irq", cpu_irq, 1);
    check("basic_c12_id", cpu_irq_id, 0);
    tick();
    check("basic_c13_irq", cpu_irq, 1);
    tick();
    ack_cycle();
    check("basic_ack_irq", cpu_irq, 0);
    check_reg("basic_ack_pending", 12'h008, 0);
    check_reg("basic_ack_status", 12'h00C, 32'h200);
    apb_write(12'h010, 32'hDEAD);
    check_reg("basic_eoi_status", 12'h00C, 32'h000);

    // Priority: source5 (3) beats source3 (2)
    apb_write(12'h000, 32'hFF);
    apb_write(12'h004, 32'h0000_0C80);
    pulse(8'h28);
    tick();
    check("prio_first_irq", cpu_irq, 1);
    check("prio_first_id", cpu_irq_id, 5);
    ack_cycle();
    check_reg("prio_status", 12'h00C, 32'h205);
    apb_write(12'h010, 0);
    check("prio_second_irq", cpu_irq, 1);
    check("prio_second_id", cpu_irq_id, 3);
    ack_cycle();
    apb_write(12'h010, 0);

    // Equal priority: lowest index first
    apb_write(12'h004, 32'h0);
    pulse(8'h42);
    tick();
    check("tie_first_id", cpu_irq_id, 1);
    check("tie_first_irq", cpu_irq, 1);
    ack_cycle();
    apb_write(12'h010, 0);
    check("tie_second_irq", cpu_irq, 1);
    check("tie_second_id", cpu_irq_id, 6);
    ack_cycle();
    apb_write(12'h010, 0);

    // Disabled source latches pending, requests once enabled
    apb_write(12'h000, 32'h00);
    pulse(8'h04);
    tick();
    check_reg("dis_pending", 12'h008, 32'h04);
    check("dis_irq", cpu_irq, 0);
    apb_write(12'h000, 32'h04);
    check("dis_enable_irq", cpu_irq, 1);
    check("dis_enable_id", cpu_irq_id, 2);
    ack_cycle();
    apb_write(12'h010, 0);

    // Software clear of the requested bit in REQ, then the same with a same-cycle ack
    apb_write(12'h000, 32'h10);
    pulse(8'h10);
    tick();
    check("w1c_req_irq", cpu_irq, 1);
    check("w1c_req_id", cpu_irq_id, 4);
    psel = 1; pwrite = 1; penable = 0; paddr = 12'h008; pwdata = 32'h10;
    tick();
    penable = 1;
    check("w1c_drop_irq", cpu_irq, 0);
    tick();
    apb_idle();
    apb_read(12'h00C, d);
    check("w1c_drop_state", (d >> 8) & 3, 0);
    check_reg("w1c_drop_pending", 12'h008, 0);
    pulse(8'h10);
    tick();
    check("w1c_ack_req_irq", cpu_irq, 1);
    psel = 1; pwrite = 1; penable = 0; paddr = 12'h008; pwdata = 32'h10; ack = 1;
    tick();
    ack = 0; penable = 1;
    check("w1c_ack_irq", cpu_irq, 0);
    tick();
    apb_idle();
    check_reg("w1c_ack_status", 12'h00C, 32'h204);
    apb_write(12'h010, 0);

    // Reset while ACTIVE with the source held high
    apb_write(12'h000, 32'h01);
    irq_src = 8'h01;
    tick();
    tick();
    check("rst_pre_irq", cpu_irq, 1);
    ack_cycle();
    rst = 1;
    tick();
    check("rst_irq", cpu_irq, 0);
    check("rst_id", cpu_irq_id, 0);
    tick();
    rst = 0;
    tick(); tick(); tick();
    check("rst_rel_irq", cpu_irq, 0);
    check_reg("rst_rel_enable", 12'h000, 0);
    check_reg("rst_rel_prio", 12'h004, 0);
    check_reg("rst_rel_pending", 12'h008, 0);
    check_reg("rst_rel_status", 12'h00C, 0);
    apb_write(12'h000, 32'h01);
    tick();
    check("rst_held_irq", cpu_irq, 0);
    check_reg("rst_held_pending", 12'h008, 0);
    irq_src = 8'h00;
    tick();
    irq_src = 8'h01;
    tick();
    check_reg("rst_newedge_pending", 12'h008, 32'h01);
    tick();
    check("rst_newedge_irq", cpu_irq, 1);
    check("rst_newedge_id", cpu_irq_id, 0);
    irq_src = 0;

    // Randomized run against the reference model
    do_reset();
    m_reset();
    in_access = 0;
    for (int c = 0; c < 3000; c++) begin
      rd = 0;
      irq_src = irq_src ^ 8'($urandom & $urandom & $urandom);
      ack = (m_state == 1) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      if (in_access) begin
        penable = 1;
        in_access = 0;
      end else begin
        apb_idle();
        r = $urandom_range(9);
        if (r < 4) begin
          psel = 1;
          pwrite = (r < 2);
          paddr = 12'(($urandom & 32'hFE0) | 32'(offs[$urandom_range(7)]));
          pwdata = $urandom;
          rd = (r >= 2);
          in_access = 1;
        end
      end
      if (rd) begin
        #1;
        check("rand_prdata", prdata, m_read(paddr));
      end
      m_step(psel, penable, pwrite, paddr, pwdata, irq_src, ack);
      tick();
      check("rand_cpu_irq", cpu_irq, 32'(m_state == 1));
      if (m_state == 1) check("rand_cpu_irq_id", cpu_irq_id, 32'(m_id));
    end
    apb_idle();
    ack = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
